// File: rtl/skew_fifo_bank.sv
// skew_fifo_bank: NCH-lane circular FIFO bank that feeds the PE array.
// Each lane is an independent first-word-fall-through FIFO. When SKEW_EN is
// set, lane k is preloaded with k zero pads on reset or flush. This means a
// vector written once per cycle reaches the array already diagonally staggered.
//
// Ports:
//   clk, rstn   clock; synchronous active-low reset
//   flush       synchronous clear to the post-reset state; beats rd/wr
//   wr, din     push one word per lane; lane k = din[k*WORDLEN +: WORDLEN]
//   rd          pop one entry (pad or data) from every non-empty lane
//   dout        per-lane head word, combinational, 0 while padding or empty
//   empty/full  per-lane occupancy flags (pads included)
//   all_empty   AND of empty
//   count       per-lane occupancy, CW bits per lane, pads included
//   ovf         sticky: some lane dropped a write

module skew_fifo_lane #(
   parameter int WORDLEN  = 8,
   parameter int DEPTH    = 16,
   parameter int CW       = 5,
   parameter int PW       = 4,
   parameter int PAD_INIT = 0
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               flush,
   input  logic               rd,
   input  logic               wr,
   input  logic [WORDLEN-1:0] din,
   output logic [WORDLEN-1:0] dout,
   output logic [CW-1:0]      cnt,
   output logic               drop
);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] PAD_C   = CW'(PAD_INIT);
   localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

   logic [WORDLEN-1:0] mem [DEPTH];
   logic [PW-1:0]      head, tail;
   logic [CW-1:0]      fifo_cnt, pad_cnt;
   logic               pad_act, fifo_ne, pop_pad, pop_fifo, push;

   assign pad_act  = (pad_cnt != '0);
   assign fifo_ne  = (fifo_cnt != '0);
   assign pop_pad  = rd && pad_act;
   assign pop_fifo = rd && !pad_act && fifo_ne;
   assign cnt      = pad_cnt + fifo_cnt;
   // A pop on the same edge (pad or data) frees the slot the write needs.
   assign push     = wr && ((cnt < DEPTH_C) || pop_pad || pop_fifo);
   assign drop     = wr && !push;
   assign dout     = (pad_act || !fifo_ne) ? '0 : mem[head];

   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         head     <= '0;
         tail     <= '0;
         fifo_cnt <= '0;
         pad_cnt  <= PAD_C;
      end else begin
         if (pop_pad)  pad_cnt <= pad_cnt - CW'(1);
         if (pop_fifo) head    <= (head == LAST) ? '0 : head + PW'(1);
         if (push)     tail    <= (tail == LAST) ? '0 : tail + PW'(1);
         case ({push, pop_fifo})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Storage is not cleared on reset or flush. Stale words stay invisible
   // because dout is gated by fifo_cnt.
   always_ff @(posedge clk) begin
      if (rstn && !flush && push) mem[tail] <= din;
   end
endmodule

module skew_fifo_bank #(
   parameter int WORDLEN = 8,
   parameter int DEPTH   = 16,
   parameter int NCH     = 4,
   parameter int SKEW_EN = 1,
   parameter int CW      = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   flush,
   input  logic                   wr,
   input  logic [NCH*WORDLEN-1:0] din,
   input  logic                   rd,
   output logic [NCH*WORDLEN-1:0] dout,
   output logic [NCH-1:0]         empty,
   output logic [NCH-1:0]         full,
   output logic                   all_empty,
   output logic [NCH*CW-1:0]      count,
   output logic                   ovf
);
   localparam int              PW      = $clog2(DEPTH);
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

   logic [NCH-1:0][WORDLEN-1:0] din_l, dout_l;
   logic [NCH-1:0][CW-1:0]      cnt_l;
   logic [NCH-1:0]              drop_l;

   assign din_l = din;
   assign dout  = dout_l;
   assign count = cnt_l;

   genvar k;
   generate
      for (k = 0; k < NCH; k++) begin : g_lane
         skew_fifo_lane #(
            .WORDLEN (WORDLEN),
            .DEPTH   (DEPTH),
            .CW      (CW),
            .PW      (PW),
            .PAD_INIT(SKEW_EN != 0 ? k : 0)
         ) u_lane (
            .clk  (clk),
            .rstn (rstn),
            .flush(flush),
            .rd   (rd),
            .wr   (wr),
            .din  (din_l[k]),
            .dout (dout_l[k]),
            .cnt  (cnt_l[k]),
            .drop (drop_l[k])
         );
         assign empty[k] = (cnt_l[k] == '0);
         assign full[k]  = (cnt_l[k] == DEPTH_C);
      end
   endgenerate

   assign all_empty = &empty;

   always_ff @(posedge clk) begin
      if (!rstn || flush) ovf <= 1'b0;
      else if (|drop_l)   ovf <= 1'b1;
   end
endmodule
